rptr_empty_fwft: RTL and testbench

- Read-side pointer and empty-flag stage of the asynchronous-comparison FIFO, in the read clock domain.
- Mirrors the write pointer/full stage on the write side.
- Produces the binary read address for the dual-port memory and the Gray read pointer for the async comparator.
- Converts the memory's combinational read port into a first-word-fall-through (FWFT) output register with a valid/accept handshake.

---
 rtl/rptr_empty_fwft.sv | 104 ++++++++++
 tb/tb_rptr_empty_fwft.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rptr_empty_fwft.sv
// Read-side pointer, empty-flag synchroniser and first-word-fall-through output stage of an async-comparison FIFO.
// Optional sticky underflow output is built when RPTR_UNDERFLOW_EN is defined.
module rptr_empty_fwft #(
  parameter int ASIZE = 4,
  parameter int DSIZE = 8
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic             rinc,
  input  logic             aempty_n,
  input  logic [DSIZE-1:0] rdata_mem,
  output logic [ASIZE-1:0] raddr,
  output logic [ASIZE-1:0] rptr,
  output logic             rempty,
  output logic [DSIZE-1:0] dout,
  output logic             dout_valid
`ifdef RPTR_UNDERFLOW_EN
  ,
  output logic             underflow
`endif
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic             r_rempty2;
  logic [ASIZE-1:0] r_rbin;
  logic [ASIZE-1:0] w_rbnext;
  logic [ASIZE-1:0] w_rgnext;
  logic             w_fetch;

  // NOTE: aempty_n is an asynchronous set; the two-flop chain only times its release into rclk.
  always_ff @(posedge rclk or negedge rrst_n or negedge aempty_n) begin
    if (!rrst_n) begin
      {rempty, r_rempty2} <= 2'b11;
    end else if (!aempty_n) begin
      {rempty, r_rempty2} <= 2'b11;
    end else begin
      {rempty, r_rempty2} <= {r_rempty2, 1'b0};
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_fetch      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!rempty) begin
          w_fetch      = 1'b1;
          w_state_next = S_HOLD;
        end
      end
      S_HOLD: begin
        if (rinc) begin
          if (!rempty) begin
            w_fetch = 1'b1;
          end else begin
            w_state_next = S_IDLE;
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign w_rbnext   = r_rbin + ASIZE'(w_fetch);
  assign w_rgnext   = (w_rbnext >> 1) ^ w_rbnext;
  assign raddr      = r_rbin;
  assign dout_valid = (r_state == S_HOLD);

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      r_state <= S_IDLE;
      r_rbin  <= '0;
      rptr    <= '0;
      dout    <= '0;
    end else begin
      r_state <= w_state_next;
      r_rbin  <= w_rbnext;
      rptr    <= w_rgnext;
      if (w_fetch) begin
        dout <= rdata_mem;
      end
    end
  end

`ifdef RPTR_UNDERFLOW_EN
  // Sticky: a consumer strobe with nothing presented is a protocol error upstream.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      underflow <= 1'b0;
    end else if (rinc && !dout_valid) begin
      underflow <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_rptr_empty_fwft.sv
// Self-checking bench for rptr_empty_fwft: model memory mem[i]=A0+i, scoreboard queue of expected dout words.
// Build with +define+RPTR_UNDERFLOW_EN to also exercise the underflow flag.
module tb_rptr_empty_fwft;

  logic       rclk = 1'b0;
  logic       rrst_n;
  logic       rinc;
  logic       aempty_n;
  logic [7:0] rdata_mem;
  logic [3:0] raddr;
  logic [3:0] rptr;
  logic       rempty;
  logic [7:0] dout;
  logic       dout_valid;
`ifdef RPTR_UNDERFLOW_EN
  logic       underflow;
`endif

  logic [7:0] mem [0:15];
  logic [7:0] sb [$];
  logic [3:0] exp_idx;
  logic [7:0] last_word;
  logic [7:0] exp_word;
  int         n_checks = 0;
  int         n_errors = 0;

  rptr_empty_fwft #(.ASIZE(4), .DSIZE(8)) dut (
    .rclk       (rclk),
    .rrst_n     (rrst_n),
    .rinc       (rinc),
    .aempty_n   (aempty_n),
    .rdata_mem  (rdata_mem),
    .raddr      (raddr),
    .rptr       (rptr),
    .rempty     (rempty),
    .dout       (dout),
    .dout_valid (dout_valid)
`ifdef RPTR_UNDERFLOW_EN
    ,
    .underflow  (underflow)
`endif
  );

  always #5 rclk = ~rclk;
  assign rdata_mem = mem[raddr];

  function automatic logic [3:0] gray(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic step();
    @(posedge rclk);
    #1;
  endtask

  // Expect one fetch on the next edge: queue the word the model memory holds at the expected address.
  task automatic expect_fetch();
    sb.push_back(mem[exp_idx]);
    exp_idx = exp_idx + 4'd1;
  endtask

  task automatic pop_and_check(input string name);
    n_checks++;
    if (sb.size() == 0) begin
      n_errors++;
      $display("FAIL %s: scoreboard empty, dout=%h", name, dout);
    end else begin
      exp_word = sb.pop_front();
      if (dout !== exp_word || dout_valid !== 1'b1) begin
        n_errors++;
        $display("FAIL %s: dout=%h valid=%b, expected dout=%h valid=1", name, dout, dout_valid, exp_word);
      end
      last_word = exp_word;
    end
  endtask

  task automatic test_reset();
    rrst_n = 1'b0; aempty_n = 1'b0; rinc = 1'b0;
    exp_idx = 4'd0;
    #12;
    n_checks++;
    if ({rempty, dout_valid, rptr, raddr, dout} !== {1'b1, 1'b0, 4'h0, 4'h0, 8'h00}) begin
      n_errors++;
      $display("FAIL reset_state: rempty=%b valid=%b rptr=%b raddr=%h dout=%h, expected 1 0 0000 0 00",
               rempty, dout_valid, rptr, raddr, dout);
    end
    step();
    rrst_n = 1'b1;
    rinc = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if ({rempty, dout_valid, rptr, raddr} !== {1'b1, 1'b0, 4'h0, 4'h0}) begin
        n_errors++;
        $display("FAIL rinc_when_empty[%0d]: rempty=%b valid=%b rptr=%b raddr=%h, expected 1 0 0000 0",
                 i, rempty, dout_valid, rptr, raddr);
      end
    end
    rinc = 1'b0;
  endtask

  task automatic test_first_word();
    aempty_n = 1'b1;
    step();
    n_checks++;
    if (rempty !== 1'b1) begin
      n_errors++;
      $display("FAIL empty_edge1: rempty=%b, expected 1", rempty);
    end
    step();
    n_checks++;
    if (rempty !== 1'b0 || dout_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL empty_edge2: rempty=%b valid=%b, expected 0 0", rempty, dout_valid);
    end
    expect_fetch();
    step();
    pop_and_check("first_word");
    n_checks++;
    if (raddr !== 4'd1 || rptr !== 4'b0001) begin
      n_errors++;
      $display("FAIL first_ptr: raddr=%h rptr=%b, expected 1 0001", raddr, rptr);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] gseq [0:4];
    gseq[0] = 4'b0011; gseq[1] = 4'b0010; gseq[2] = 4'b0110; gseq[3] = 4'b0111; gseq[4] = 4'b0101;
    rinc = 1'b1;
    for (int i = 0; i < 5; i++) begin
      expect_fetch();
      step();
      pop_and_check("b2b_word");
      n_checks++;
      if (rptr !== gseq[i] || raddr !== exp_idx) begin
        n_errors++;
        $display("FAIL b2b_ptr[%0d]: rptr=%b raddr=%h, expected %b %h", i, rptr, raddr, gseq[i], exp_idx);
      end
    end
    rinc = 1'b0;
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (dout !== last_word || dout_valid !== 1'b1 || rptr !== gray(exp_idx)) begin
        n_errors++;
        $display("FAIL hold[%0d]: dout=%h valid=%b rptr=%b, expected %h 1 %b",
                 i, dout, dout_valid, rptr, last_word, gray(exp_idx));
      end
    end
    aempty_n = 1'b0;
    rinc = 1'b1;
    step();
    n_checks++;
    if (dout_valid !== 1'b0 || rempty !== 1'b1 || raddr !== exp_idx || dout !== last_word) begin
      n_errors++;
      $display("FAIL drain: valid=%b rempty=%b raddr=%h dout=%h, expected 0 1 %h %h",
               dout_valid, rempty, raddr, dout, exp_idx, last_word);
    end
    rinc = 1'b0;
    step();
    n_checks++;
    if (dout_valid !== 1'b0 || raddr !== exp_idx) begin
      n_errors++;
      $display("FAIL idle_after_drain: valid=%b raddr=%h, expected 0 %h", dout_valid, raddr, exp_idx);
    end
  endtask

  task automatic test_wrap();
    #2 rrst_n = 1'b0;
    #2 rrst_n = 1'b1;
    exp_idx = 4'd0;
    sb.delete();
    aempty_n = 1'b1;
    rinc = 1'b1;
    step();
    step();
    n_checks++;
    if (rempty !== 1'b0 || dout_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL wrap_start: rempty=%b valid=%b, expected 0 0", rempty, dout_valid);
    end
    for (int k = 0; k < 16; k++) begin
      expect_fetch();
      step();
      pop_and_check("wrap_word");
      n_checks++;
      if (raddr !== exp_idx || rptr !== gray(exp_idx)) begin
        n_errors++;
        $display("FAIL wrap_ptr[%0d]: raddr=%h rptr=%b, expected %h %b", k, raddr, rptr, exp_idx, gray(exp_idx));
      end
    end
    n_checks++;
    if (dout !== 8'hAF || raddr !== 4'd0 || rptr !== 4'b0000) begin
      n_errors++;
      $display("FAIL wrap_end: dout=%h raddr=%h rptr=%b, expected af 0 0000", dout, raddr, rptr);
    end
  endtask

  task automatic test_mid_reset();
    expect_fetch();
    step();
    pop_and_check("pre_reset_word");
    #3 rrst_n = 1'b0;
    #1;
    n_checks++;
    if ({rempty, dout_valid, rptr, raddr, dout} !== {1'b1, 1'b0, 4'h0, 4'h0, 8'h00}) begin
      n_errors++;
      $display("FAIL mid_reset: rempty=%b valid=%b rptr=%b raddr=%h dout=%h, expected 1 0 0000 0 00",
               rempty, dout_valid, rptr, raddr, dout);
    end
    rinc = 1'b0;
    aempty_n = 1'b0;
    #2 rrst_n = 1'b1;
    exp_idx = 4'd0;
    sb.delete();
  endtask

`ifdef RPTR_UNDERFLOW_EN
  task automatic test_underflow();
    step();
    n_checks++;
    if (underflow !== 1'b0) begin
      n_errors++;
      $display("FAIL underflow_reset: underflow=%b, expected 0", underflow);
    end
    rinc = 1'b1;
    step();
    rinc = 1'b0;
    n_checks++;
    if (underflow !== 1'b1) begin
      n_errors++;
      $display("FAIL underflow_set: underflow=%b, expected 1", underflow);
    end
    aempty_n = 1'b1;
    step();
    step();
    expect_fetch();
    step();
    pop_and_check("uf_first_word");
    rinc = 1'b1;
    expect_fetch();
    step();
    pop_and_check("uf_second_word");
    rinc = 1'b0;
    n_checks++;
    if (underflow !== 1'b1) begin
      n_errors++;
      $display("FAIL underflow_sticky: underflow=%b, expected 1", underflow);
    end
    #2 rrst_n = 1'b0;
    #1;
    n_checks++;
    if (underflow !== 1'b0) begin
      n_errors++;
      $display("FAIL underflow_clear: underflow=%b, expected 0", underflow);
    end
    #2 rrst_n = 1'b1;
  endtask
`endif

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'hA0 + 8'(i);
    test_reset();
    test_first_word();
    test_back_to_back();
    test_backpressure();
    test_wrap();
    test_mid_reset();
`ifdef RPTR_UNDERFLOW_EN
    test_underflow();
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
